fmlbrg_datamem: RTL and testbench
=================================

Name: fmlbrg_datamem

Overview:
- Data store of the FML bridge cache.
- 16-bit-wide, 2^depth-word synchronous single-port SRAM with per-byte write enables and write-first read semantics.
- The bridge FSM uses it to:
  - serve WISHBONE read hits,
  - merge WISHBONE byte writes,
  - absorb 8-word FML refill bursts,
  - supply eviction data to FML.

Parameters:
- depth, 8, address width in 16-bit words; capacity = 2^depth words (default 256 words = 512 bytes).

Ports:
- sys_clk  input  1  single clock; all state updates on rising edge.
- sys_rst_n  input  1  asynchronous, active-low reset; clears the internal read-address register only.
- a  input  depth  word address, used for both write and read.
- we  input  2  byte write enables; we[0] writes di[7:0], we[1] writes di[15:8].
- di  input  16  write data.
- do  output  16  read data.

Behaviour:
- Storage: two byte lanes of 2^depth x 8 bits each (lane0 = bits 7:0, lane1 = bits 15:8).
  - Contents are not initialised and not affected by reset.
  - Simulation model may preload zeros.
- Write: at a rising edge, for each lane k with we[k]=1, mem_k[a] <= di lane k. Lanes with we[k]=0 keep their value.
- Address register: at every rising edge, a_r <= a, whether or not a write occurs.
- Read: do = {mem_1[a_r], mem_0[a_r]}, a combinational read of the registered address.
  - Read latency is 1 cycle: address presented in cycle t gives data valid after the edge ending cycle t.
- Write-first: when a write and a read target the same address A at the same edge, do after that edge shows the new bytes for enabled lanes and the old bytes for disabled lanes. Stale data is never returned.
- do always tracks the current contents at a_r. A later write to a_r while a is held at A updates do after that write edge.
- we=2'b00: pure read, no array change.
- Partial writes (we=01 or 10) must not disturb the other lane; this is the WISHBONE byte-select path.
- Address wrap: a is exactly depth bits. There are no out-of-range addresses and no other address checks.
- Reset: while sys_rst_n=0, a_r is forced to 0, so do = word 0, and array writes are still performed if we≠0. a_r resumes capturing a on the first edge after deassertion.
- Reset asserted mid-operation: only the a_r value is affected; previously written data is retained.
- No handshake, no stall: the block accepts one access per cycle, back-to-back, with no idle cycles.
- Must infer block RAM: no reset on the array, and no read-enable gating.

Decomposition:
- No shared package needed; depth is the only constant and is passed by the parent (cache_depth-1).
- One natural sub-module: fmlbrg_datamem_lane, an 8-bit x 2^depth write-first RAM with a registered address, instantiated twice (we[0]/di[7:0], we[1]/di[15:8]).
- The top level only splits and concatenates the lanes.

Test Plan:
- Full write/readback: write addr 0x05 di=0xA5C3 we=11, then read addr 0x05 with we=00 -> do=0xA5C3 one cycle later.
- Write-first same cycle:
  - Preload 0x10=0x1111.
  - Present a=0x10, we=11, di=0xBEEF -> do=0xBEEF immediately after that edge, never 0x1111.
- Byte lanes:
  - Preload 0x20=0x1234.
  - Write we=01 di=0xFFAA -> read 0x12AA.
  - Then we=10 di=0x55FF -> read 0x55AA.
- Back-to-back burst: write addresses 0x30..0x37 on consecutive cycles with di=addr*0x0101 -> a sequential readback gives one word per cycle, each matching, with 1-cycle latency.
- Boundary: write 0x0000 at address 0 and 0xFFFF at address 2^depth-1 (0xFF) -> both read back intact; no aliasing.
- Reset mid-run:
  - With 0x40=0xCAFE and 0x00=0x0001, hold a=0x40 and assert sys_rst_n=0 asynchronously -> do=0x0001 immediately.
  - Release; next edge -> do=0xCAFE, data retained.

Source files
------------

// File: rtl/fmlbrg_datamem_lane.sv
// One byte lane of the bridge cache data store: 8-bit x 2^depth RAM with a
// registered read address, so a same-edge write is visible on the next read.
module fmlbrg_datamem_lane #(
  parameter int depth = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [depth-1:0] a,
  input  logic             we,
  input  logic [7:0]       di,
  output logic [7:0]       dout
);

  logic [7:0]       mem_r [0:(1<<depth)-1];
  logic [depth-1:0] a_r;

  // Array write; left unreset so the lane maps onto block RAM.
  always_ff @(posedge sys_clk) begin
    if (we) begin
      mem_r[a] <= di;
    end
  end

  // Read address capture; reset only steers the read port to word 0.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      a_r <= {depth{1'b0}};
    end else begin
      a_r <= a;
    end
  end

  // Reading through the registered address yields write-first behaviour.
  assign dout = mem_r[a_r];

endmodule

// File: rtl/fmlbrg_datamem.sv
// Data store of the FML bridge cache: 16-bit words built from two independent
// byte lanes so WISHBONE byte selects merge without read-modify-write.
module fmlbrg_datamem #(
  parameter int depth = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [depth-1:0] a,
  input  logic [1:0]       we,
  input  logic [15:0]      di,
  output logic [15:0]      dout
);

  logic [7:0] lane0_do_s;
  logic [7:0] lane1_do_s;

  fmlbrg_datamem_lane #(.depth(depth)) u_lane0 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .a         (a),
    .we        (we[0]),
    .di        (di[7:0]),
    .dout      (lane0_do_s)
  );

  fmlbrg_datamem_lane #(.depth(depth)) u_lane1 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .a         (a),
    .we        (we[1]),
    .di        (di[15:8]),
    .dout      (lane1_do_s)
  );

  assign dout = {lane1_do_s, lane0_do_s};

endmodule

// File: tb/tb_fmlbrg_datamem.sv
// Self-checking bench for fmlbrg_datamem against a word-array reference model.
module tb_fmlbrg_datamem;

  localparam int DEPTH = 8;
  localparam int WORDS = 1 << DEPTH;

  logic             sys_clk;
  logic             sys_rst_n;
  logic [DEPTH-1:0] a;
  logic [1:0]       we;
  logic [15:0]      di;
  logic [15:0]      dout;

  logic [15:0]      mem_m [0:WORDS-1];
  logic [DEPTH-1:0] ar_m;
  int               checks;
  int               errors;

  fmlbrg_datamem #(.depth(DEPTH)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .a         (a),
    .we        (we),
    .di        (di),
    .dout      (dout)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // One access: present inputs, take an edge, update the model, settle.
  task automatic access(input logic [DEPTH-1:0] addr, input logic [1:0] w,
                        input logic [15:0] d);
    a  = addr;
    we = w;
    di = d;
    @(posedge sys_clk);
    if (w[0]) mem_m[addr][7:0]  = d[7:0];
    if (w[1]) mem_m[addr][15:8] = d[15:8];
    ar_m = sys_rst_n ? addr : 8'h00;
    #1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    access(8'h00, 2'b11, 16'h0001);
    checks++;
    if (dout !== 16'h0001) begin
      errors++;
      $display("FAIL reset_write_word0 got %h expected %h", dout, 16'h0001);
    end
    access(8'h77, 2'b00, 16'h0000);
    checks++;
    if (dout !== 16'h0001) begin
      errors++;
      $display("FAIL reset_holds_addr0 got %h expected %h", dout, 16'h0001);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_full_write();
    access(8'h05, 2'b11, 16'hA5C3);
    access(8'h05, 2'b00, 16'h0000);
    checks++;
    if (dout !== 16'hA5C3) begin
      errors++;
      $display("FAIL full_write got %h expected %h", dout, 16'hA5C3);
    end
  endtask

  task automatic test_write_first();
    access(8'h10, 2'b11, 16'h1111);
    access(8'h10, 2'b11, 16'hBEEF);
    checks++;
    if (dout !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_first got %h expected %h", dout, 16'hBEEF);
    end
    access(8'h10, 2'b01, 16'h0042);
    checks++;
    if (dout !== 16'hBE42) begin
      errors++;
      $display("FAIL write_first_partial got %h expected %h", dout, 16'hBE42);
    end
  endtask

  task automatic test_byte_lanes();
    access(8'h20, 2'b11, 16'h1234);
    access(8'h20, 2'b01, 16'hFFAA);
    access(8'h20, 2'b00, 16'h0000);
    checks++;
    if (dout !== 16'h12AA) begin
      errors++;
      $display("FAIL lane0_only got %h expected %h", dout, 16'h12AA);
    end
    access(8'h20, 2'b10, 16'h55FF);
    access(8'h20, 2'b00, 16'h0000);
    checks++;
    if (dout !== 16'h55AA) begin
      errors++;
      $display("FAIL lane1_only got %h expected %h", dout, 16'h55AA);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_v;
    for (int i = 0; i < 8; i++) begin
      exp_v = 16'((8'h30 + i) * 16'h0101);
      access(8'(8'h30 + i), 2'b11, exp_v);
    end
    for (int i = 0; i < 8; i++) begin
      exp_v = 16'((8'h30 + i) * 16'h0101);
      access(8'(8'h30 + i), 2'b00, 16'h0000);
      checks++;
      if (dout !== exp_v) begin
        errors++;
        $display("FAIL burst_read idx %0d got %h expected %h", i, dout, exp_v);
      end
      // Next address presented; output must not change before the edge.
      if (i < 7) begin
        a = 8'(8'h31 + i);
        #2;
        checks++;
        if (dout !== exp_v) begin
          errors++;
          $display("FAIL burst_latency idx %0d got %h expected %h", i, dout, exp_v);
        end
      end
    end
  endtask

  task automatic test_boundary();
    access(8'h00, 2'b11, 16'h0000);
    access(8'hFF, 2'b11, 16'hFFFF);
    access(8'h00, 2'b00, 16'h0000);
    checks++;
    if (dout !== 16'h0000) begin
      errors++;
      $display("FAIL boundary_low got %h expected %h", dout, 16'h0000);
    end
    access(8'hFF, 2'b00, 16'h0000);
    checks++;
    if (dout !== 16'hFFFF) begin
      errors++;
      $display("FAIL boundary_high got %h expected %h", dout, 16'hFFFF);
    end
  endtask

  task automatic test_reset_mid();
    access(8'h40, 2'b11, 16'hCAFE);
    access(8'h00, 2'b11, 16'h0001);
    access(8'h40, 2'b00, 16'h0000);
    checks++;
    if (dout !== 16'hCAFE) begin
      errors++;
      $display("FAIL reset_mid_pre got %h expected %h", dout, 16'hCAFE);
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 16'h0001) begin
      errors++;
      $display("FAIL reset_mid_async got %h expected %h", dout, 16'h0001);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    ar_m = a;
    #1;
    checks++;
    if (dout !== 16'hCAFE) begin
      errors++;
      $display("FAIL reset_mid_release got %h expected %h", dout, 16'hCAFE);
    end
  endtask

  task automatic test_random();
    logic [DEPTH-1:0] addr;
    logic [1:0]       w;
    logic [15:0]      d;
    for (int i = 0; i < WORDS; i++) begin
      access(8'(i), 2'b11, 16'($urandom));
    end
    for (int i = 0; i < 300; i++) begin
      addr = 8'($urandom_range(0, WORDS - 1));
      if ($urandom_range(0, 3) == 0) addr = ar_m;
      w = 2'($urandom);
      d = 16'($urandom);
      access(addr, w, d);
      checks++;
      if (dout !== mem_m[ar_m]) begin
        errors++;
        $display("FAIL random idx %0d addr %h we %b got %h expected %h",
                 i, addr, w, dout, mem_m[ar_m]);
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    sys_rst_n = 1'b0;
    a         = 8'h00;
    we        = 2'b00;
    di        = 16'h0000;
    ar_m      = 8'h00;
    for (int i = 0; i < WORDS; i++) mem_m[i] = 16'h0000;
    #2;
    test_reset();
    test_full_write();
    test_write_first();
    test_byte_lanes();
    test_back_to_back();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
